gray_counter_ext: RTL and testbench

Parametrised Gray-code counter: the general-purpose successor to the fixed 3-bit up-only Gray counter. It adds configurable width, up/down counting, wrap or saturate at the end of the range, parallel load of a Gray value, and sticky overflow/underflow flags that software can clear. It sits in the same counter/sequencer library and serves as a drop-in sequence source for multi-bit pointers and state encoders, where single-bit-change outputs matter.

---
 rtl/gray_counter_ext_if.sv | 42 ++++
 rtl/gray_counter_ext.sv | 101 ++++++++++
 tb/tb_gray_counter_ext.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_ext_if.sv
// Handshake-free control/status bundle for gray_counter_ext.
// master drives controls and observes count; slave is the counter.
interface gray_counter_ext_if #(
    parameter int WIDTH = 3
);
    logic             En;
    logic             Dir;
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
    logic             ClrFlag;
    logic [WIDTH-1:0] Output;
    logic [WIDTH-1:0] Binary;
    logic             Overflow;
    logic             Underflow;
    logic             Terminal;

    modport master (
        output En,
        output Dir,
        output Load,
        output LoadValue,
        output ClrFlag,
        input  Output,
        input  Binary,
        input  Overflow,
        input  Underflow,
        input  Terminal
    );

    modport slave (
        input  En,
        input  Dir,
        input  Load,
        input  LoadValue,
        input  ClrFlag,
        output Output,
        output Binary,
        output Overflow,
        output Underflow,
        output Terminal
    );
endinterface

// File: rtl/gray_counter_ext.sv
// Parametrised up/down Gray counter with wrap/saturate,
// Gray-encoded parallel load and sticky end-of-range flags.
module gray_counter_ext #(
    parameter int WIDTH = 3,
    parameter bit WRAP  = 1'b1
) (
    input logic               Clk,
    input logic               Reset,
    gray_counter_ext_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;
    logic             r_unf;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_ovf_next;
    logic             w_unf_next;

    assign w_at_max  = (r_bin == MAX_VAL);
    assign w_at_zero = (r_bin == '0);

    // Gray-to-binary of the load value: prefix XOR from the MSB down.
    always_comb begin
        w_load_bin[WIDTH-1] = bus.LoadValue[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            w_load_bin[i] = w_load_bin[i+1] ^ bus.LoadValue[i];
        end
    end

    // Next binary count and end-of-range events; load beats count.
    always_comb begin
        w_bin_next = r_bin;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        if (bus.Load) begin
            w_bin_next = w_load_bin;
        end else if (bus.En) begin
            if (!bus.Dir) begin
                if (w_at_max) begin
                    w_ovf_set = 1'b1;
                    if (WRAP) begin
                        w_bin_next = '0;
                    end
                end else begin
                    w_bin_next = r_bin + ONE_VAL;
                end
            end else begin
                if (w_at_zero) begin
                    w_unf_set = 1'b1;
                    if (WRAP) begin
                        w_bin_next = MAX_VAL;
                    end
                end else begin
                    w_bin_next = r_bin - ONE_VAL;
                end
            end
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    always_comb begin
        w_ovf_next = w_ovf_set | (r_ovf & ~bus.ClrFlag);
        w_unf_next = w_unf_set | (r_unf & ~bus.ClrFlag);
    end

    // Gray image of the next count, registered alongside it.
    always_comb begin
        w_gray_next = w_bin_next ^ (w_bin_next >> 1);
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_ovf  <= w_ovf_next;
            r_unf  <= w_unf_next;
        end
    end

    assign bus.Output    = r_gray;
    assign bus.Binary    = r_bin;
    assign bus.Overflow  = r_ovf;
    assign bus.Underflow = r_unf;
    assign bus.Terminal  = (~bus.Dir & w_at_max) | (bus.Dir & w_at_zero);
endmodule

// File: tb/tb_gray_counter_ext.sv
// Bench for gray_counter_ext: directed scenarios on three
// configurations plus randomized traffic against a count model.
module tb_gray_counter_ext;
    logic Clk;
    logic rst3, rst4, rst5;
    int   n_cmp;
    int   n_bad;

    gray_counter_ext_if #(.WIDTH(3)) b3 ();
    gray_counter_ext_if #(.WIDTH(4)) b4 ();
    gray_counter_ext_if #(.WIDTH(5)) b5 ();

    gray_counter_ext #(.WIDTH(3), .WRAP(1'b1)) u3 (
        .Clk(Clk), .Reset(rst3), .bus(b3.slave));
    gray_counter_ext #(.WIDTH(4), .WRAP(1'b0)) u4 (
        .Clk(Clk), .Reset(rst4), .bus(b4.slave));
    gray_counter_ext #(.WIDTH(5), .WRAP(1'b1)) u5 (
        .Clk(Clk), .Reset(rst5), .bus(b5.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: count as a plain integer in [0, 2^w-1].
    function automatic void mstep(
        input int w, input bit wrap, input bit rst, input bit ld,
        input int lv, input bit en, input bit dir, input bit clr,
        inout int b, inout bit ov, inout bit un);
        int mx;
        bit so;
        bit su;
        mx = (1 << w) - 1;
        so = 1'b0;
        su = 1'b0;
        if (rst) begin
            b = 0; ov = 1'b0; un = 1'b0;
            return;
        end
        if (ld) begin
            b = 0;
            for (int k = 0; k < w; k++) b = b ^ (lv >> k);
        end else if (en) begin
            if (!dir) begin
                if (b == mx) begin so = 1'b1; if (wrap) b = 0; end
                else b = b + 1;
            end else begin
                if (b == 0) begin su = 1'b1; if (wrap) b = mx; end
                else b = b - 1;
            end
        end
        ov = so | (ov & !clr);
        un = su | (un & !clr);
    endfunction

    task automatic test_reset();
        rst3 = 1; rst4 = 1; rst5 = 1;
        b3.Load = 1; b3.LoadValue = 3'b110; b3.ClrFlag = 1;
        tick();
        n_cmp++;
        if (b3.Output !== 3'd0 || b3.Binary !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_w3 out=%b bin=%0d want 0/0", b3.Output, b3.Binary);
        end
        n_cmp++;
        if (b3.Overflow !== 1'b0 || b3.Underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags ov=%b un=%b want 0/0", b3.Overflow, b3.Underflow);
        end
        n_cmp++;
        if (b4.Output !== 4'd0 || b5.Output !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_w4w5 o4=%b o5=%b want 0", b4.Output, b5.Output);
        end
        rst3 = 0; rst4 = 0; rst5 = 0;
        b3.Load = 0; b3.ClrFlag = 0;
    endtask

    task automatic test_up_wrap();
        logic [2:0] seq [9];
        logic [2:0] cur;
        seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                3'b101, 3'b100, 3'b000, 3'b001};
        cur = 3'b000;
        b3.En = 1; b3.Dir = 0;
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (b3.Terminal !== (cur == 3'b100)) begin
                n_bad++;
                $display("FAIL upwrap_term step=%0d got=%b want=%b", k, b3.Terminal, cur == 3'b100);
            end
            tick();
            cur = seq[k];
            n_cmp++;
            if (b3.Output !== cur || b3.Overflow !== (k >= 7)) begin
                n_bad++;
                $display("FAIL upwrap step=%0d out=%b ov=%b want %b/%b", k, b3.Output, b3.Overflow, cur, k >= 7);
            end
        end
        b3.En = 0;
    endtask

    task automatic test_down_underflow();
        rst3 = 1; tick(); rst3 = 0;
        b3.En = 1; b3.Dir = 1;
        tick();
        n_cmp++;
        if (b3.Output !== 3'b100 || b3.Binary !== 3'd7 ||
            b3.Underflow !== 1'b1 || b3.Overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL down1 out=%b bin=%0d un=%b ov=%b want 100/7/1/0", b3.Output, b3.Binary, b3.Underflow, b3.Overflow);
        end
        tick();
        n_cmp++;
        if (b3.Output !== 3'b101 || b3.Binary !== 3'd6 || b3.Overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL down2 out=%b bin=%0d ov=%b want 101/6/0", b3.Output, b3.Binary, b3.Overflow);
        end
        b3.En = 0; b3.Dir = 0;
    endtask

    task automatic test_hold();
        rst3 = 1; tick(); rst3 = 0;
        b3.En = 1; b3.Dir = 0;
        tick(); tick();
        b3.En = 0;
        for (int k = 0; k < 5; k++) begin
            b3.Dir = ~b3.Dir;
            #1;
            n_cmp++;
            if (b3.Terminal !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_term step=%0d got=%b want 0", k, b3.Terminal);
            end
            tick();
            n_cmp++;
            if (b3.Output !== 3'b011 || b3.Overflow !== 1'b0 || b3.Underflow !== 1'b0) begin
                n_bad++;
                $display("FAIL hold step=%0d out=%b ov=%b un=%b want 011/0/0", k, b3.Output, b3.Overflow, b3.Underflow);
            end
        end
        b3.Dir = 0;
    endtask

    task automatic test_saturate();
        b4.Load = 1; b4.LoadValue = 4'b1000;
        tick();
        b4.Load = 0;
        n_cmp++;
        if (b4.Binary !== 4'd15 || b4.Output !== 4'b1000) begin
            n_bad++;
            $display("FAIL sat_load bin=%0d out=%b want 15/1000", b4.Binary, b4.Output);
        end
        b4.En = 1; b4.Dir = 0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (b4.Terminal !== 1'b1) begin
                n_bad++;
                $display("FAIL sat_term step=%0d got=%b want 1", k, b4.Terminal);
            end
            tick();
            n_cmp++;
            if (b4.Output !== 4'b1000 || b4.Overflow !== 1'b1) begin
                n_bad++;
                $display("FAIL sat_hold step=%0d out=%b ov=%b want 1000/1", k, b4.Output, b4.Overflow);
            end
        end
        b4.Dir = 1;
        tick();
        n_cmp++;
        if (b4.Output !== 4'b1001 || b4.Binary !== 4'd14) begin
            n_bad++;
            $display("FAIL sat_down out=%b bin=%0d want 1001/14", b4.Output, b4.Binary);
        end
        b4.En = 0; b4.Dir = 0;
    endtask

    task automatic test_load_priority();
        b4.Load = 1; b4.En = 1; b4.Dir = 0; b4.LoadValue = 4'b0110;
        tick();
        n_cmp++;
        if (b4.Binary !== 4'd4 || b4.Output !== 4'b0110) begin
            n_bad++;
            $display("FAIL load_prio bin=%0d out=%b want 4/0110", b4.Binary, b4.Output);
        end
        b4.En = 0; b4.LoadValue = 4'b1000;
        tick();
        b4.Load = 0;
        b4.En = 1; b4.ClrFlag = 1;
        tick();
        n_cmp++;
        if (b4.Overflow !== 1'b1 || b4.Output !== 4'b1000) begin
            n_bad++;
            $display("FAIL clr_race ov=%b out=%b want 1/1000", b4.Overflow, b4.Output);
        end
        b4.En = 0;
        tick();
        n_cmp++;
        if (b4.Overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_alone ov=%b want 0", b4.Overflow);
        end
        b4.ClrFlag = 0;
    endtask

    task automatic test_reset_mid();
        rst5 = 1; tick(); rst5 = 0;
        b5.En = 1; b5.Dir = 1;
        tick();
        b5.En = 0; b5.Dir = 0;
        b5.Load = 1; b5.LoadValue = 5'b11011;
        tick();
        b5.Load = 0; b5.En = 1;
        tick();
        n_cmp++;
        if (b5.Binary !== 5'd19 || b5.Underflow !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_setup bin=%0d un=%b want 19/1", b5.Binary, b5.Underflow);
        end
        rst5 = 1; b5.Load = 1; b5.ClrFlag = 1;
        b5.LoadValue = 5'($urandom_range(1, 31));
        tick();
        n_cmp++;
        if (b5.Output !== 5'd0 || b5.Binary !== 5'd0 ||
            b5.Overflow !== 1'b0 || b5.Underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset out=%b bin=%0d ov=%b un=%b want 0", b5.Output, b5.Binary, b5.Overflow, b5.Underflow);
        end
        rst5 = 0; b5.Load = 0; b5.ClrFlag = 0;
        tick();
        n_cmp++;
        if (b5.Output !== 5'b00001) begin
            n_bad++;
            $display("FAIL mid_release out=%b want 00001", b5.Output);
        end
        b5.En = 0;
    endtask

    task automatic test_random();
        int w  [3];
        bit wr [3];
        int mb [3];
        bit mo [3];
        bit mu [3];
        bit rs [3], ld [3], en [3], dr [3], cl [3];
        int lv [3];
        int ob [3], og [3];
        bit oo [3], ou [3], ot [3];
        w = '{3, 4, 5};
        wr = '{1'b1, 1'b0, 1'b1};
        mb = '{0, 0, 0};
        mo = '{1'b0, 1'b0, 1'b0};
        mu = '{1'b0, 1'b0, 1'b0};
        for (int it = 0; it < 400; it++) begin
            for (int d = 0; d < 3; d++) begin
                rs[d] = (it == 0) || ($urandom_range(0, 49) == 0);
                ld[d] = ($urandom_range(0, 9) == 0);
                en[d] = ($urandom_range(0, 9) < 7);
                dr[d] = ($urandom_range(0, 2) == 0) ? ~dr[d] : dr[d];
                cl[d] = ($urandom_range(0, 9) == 0);
                lv[d] = $urandom_range(0, (1 << w[d]) - 1);
            end
            rst3 = rs[0]; b3.Load = ld[0]; b3.En = en[0];
            b3.Dir = dr[0]; b3.ClrFlag = cl[0]; b3.LoadValue = 3'(lv[0]);
            rst4 = rs[1]; b4.Load = ld[1]; b4.En = en[1];
            b4.Dir = dr[1]; b4.ClrFlag = cl[1]; b4.LoadValue = 4'(lv[1]);
            rst5 = rs[2]; b5.Load = ld[2]; b5.En = en[2];
            b5.Dir = dr[2]; b5.ClrFlag = cl[2]; b5.LoadValue = 5'(lv[2]);
            #1;
            ot[0] = b3.Terminal; ot[1] = b4.Terminal; ot[2] = b5.Terminal;
            if (it > 0) begin
                for (int d = 0; d < 3; d++) begin
                    n_cmp++;
                    if (ot[d] !== ((!dr[d] && mb[d] == (1 << w[d]) - 1) || (dr[d] && mb[d] == 0))) begin
                        n_bad++;
                        $display("FAIL rnd_term dut=%0d it=%0d got=%b count=%0d dir=%b", d, it, ot[d], mb[d], dr[d]);
                    end
                end
            end
            tick();
            for (int d = 0; d < 3; d++)
                mstep(w[d], wr[d], rs[d], ld[d], lv[d], en[d], dr[d], cl[d], mb[d], mo[d], mu[d]);
            ob[0] = int'(b3.Binary); og[0] = int'(b3.Output);
            oo[0] = b3.Overflow; ou[0] = b3.Underflow;
            ob[1] = int'(b4.Binary); og[1] = int'(b4.Output);
            oo[1] = b4.Overflow; ou[1] = b4.Underflow;
            ob[2] = int'(b5.Binary); og[2] = int'(b5.Output);
            oo[2] = b5.Overflow; ou[2] = b5.Underflow;
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (ob[d] !== mb[d] || og[d] !== (mb[d] ^ (mb[d] >> 1)) ||
                    oo[d] !== mo[d] || ou[d] !== mu[d]) begin
                    n_bad++;
                    $display("FAIL rnd_state dut=%0d it=%0d bin=%0d gray=%0d ov=%b un=%b want %0d/%0d/%b/%b",
                             d, it, ob[d], og[d], oo[d], ou[d], mb[d], mb[d] ^ (mb[d] >> 1), mo[d], mu[d]);
                end
            end
        end
        rst3 = 0; rst4 = 0; rst5 = 0;
        b3.Load = 0; b3.En = 0; b3.ClrFlag = 0;
        b4.Load = 0; b4.En = 0; b4.ClrFlag = 0;
        b5.Load = 0; b5.En = 0; b5.ClrFlag = 0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst3 = 1; rst4 = 1; rst5 = 1;
        b3.En = 0; b3.Dir = 0; b3.Load = 0; b3.LoadValue = '0; b3.ClrFlag = 0;
        b4.En = 0; b4.Dir = 0; b4.Load = 0; b4.LoadValue = '0; b4.ClrFlag = 0;
        b5.En = 0; b5.Dir = 0; b5.Load = 0; b5.LoadValue = '0; b5.ClrFlag = 0;
        tick();
        test_reset();
        test_up_wrap();
        test_down_underflow();
        test_hold();
        test_saturate();
        test_load_priority();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
